// File: rtl/ct_mmu_sysmap_match_pipe_if.sv
// Lookup / response / region-config bundle for the system-map matcher.
// The slave modport is the matcher side; the master modport is the requester side.
interface ct_mmu_sysmap_match_pipe_if #(
    parameter int IDX_W  = 3,
    parameter int AW     = 28,
    parameter int ATTR_W = 5
);
    logic              cfg_wen;
    logic [IDX_W-1:0]  cfg_idx;
    logic [AW-1:0]     cfg_top;
    logic [ATTR_W-1:0] cfg_attr;
    logic              lkp_vld;
    logic              lkp_rdy;
    logic [AW-1:0]     lkp_addr;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic              rsp_hit;
    logic [IDX_W-1:0]  rsp_idx;
    logic [ATTR_W-1:0] rsp_attr;

    modport master (
        output cfg_wen, cfg_idx, cfg_top, cfg_attr, lkp_vld, lkp_addr, rsp_rdy,
        input  lkp_rdy, rsp_vld, rsp_hit, rsp_idx, rsp_attr
    );

    modport slave (
        input  cfg_wen, cfg_idx, cfg_top, cfg_attr, lkp_vld, lkp_addr, rsp_rdy,
        output lkp_rdy, rsp_vld, rsp_hit, rsp_idx, rsp_attr
    );
endinterface

// File: rtl/ct_mmu_sysmap_match_pipe.sv
// Two-stage system-map region matcher: stage 1 captures the per-region hit vector,
// stage 2 priority-encodes it into a registered hit/index/attribute response.
module ct_mmu_sysmap_match_pipe #(
    parameter int                NUM_ENTRY    = 8,
    parameter int                IDX_W        = 3,
    parameter int                AW           = 28,
    parameter int                ATTR_W       = 5,
    parameter logic [ATTR_W-1:0] DEFAULT_ATTR = {ATTR_W{1'b0}}
) (
    input  logic                         forever_cpuclk,
    input  logic                         cpurst,
    ct_mmu_sysmap_match_pipe_if.slave    bus
);

    // Lowest set bit wins; MSB of the result flags whether any bit was set.
    function automatic logic [IDX_W:0] prio_enc(input logic [NUM_ENTRY-1:0] vec);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    logic [AW-1:0]        top_q  [NUM_ENTRY];
    logic [AW-1:0]        top_d  [NUM_ENTRY];
    logic [ATTR_W-1:0]    attr_q [NUM_ENTRY];
    logic [ATTR_W-1:0]    attr_d [NUM_ENTRY];

    logic                 s1_vld_q,   s1_vld_d;
    logic [NUM_ENTRY-1:0] s1_hit_q,   s1_hit_d;
    logic                 rsp_vld_q,  rsp_vld_d;
    logic                 rsp_hit_q,  rsp_hit_d;
    logic [IDX_W-1:0]     rsp_idx_q,  rsp_idx_d;
    logic [ATTR_W-1:0]    rsp_attr_q, rsp_attr_d;

    logic [NUM_ENTRY-1:0] hit_vec_s;
    logic [IDX_W:0]       enc_s;
    logic                 out_free_s;
    logic                 lkp_rdy_s;
    logic                 accept_s;
    logic                 adv_s;

    // Region compare; an empty region (top <= bottom) can never satisfy both bounds.
    always_comb begin
        hit_vec_s    = {NUM_ENTRY{1'b0}};
        hit_vec_s[0] = (bus.lkp_addr < top_q[0]);
        for (int i = 1; i < NUM_ENTRY; i++) begin
            hit_vec_s[i] = (bus.lkp_addr >= top_q[i-1]) && (bus.lkp_addr < top_q[i]);
        end
    end

    // Region register update; indices beyond the table match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
            top_d[i]  = (bus.cfg_wen && (bus.cfg_idx == IDX_W'(i))) ? bus.cfg_top  : top_q[i];
            attr_d[i] = (bus.cfg_wen && (bus.cfg_idx == IDX_W'(i))) ? bus.cfg_attr : attr_q[i];
        end
    end

    // Pipeline flow control and next-state of both stages.
    always_comb begin
        out_free_s = !rsp_vld_q || bus.rsp_rdy;
        lkp_rdy_s  = !s1_vld_q || out_free_s;
        accept_s   = bus.lkp_vld && lkp_rdy_s;
        adv_s      = out_free_s && s1_vld_q;
        enc_s      = prio_enc(s1_hit_q);

        s1_vld_d   = accept_s ? 1'b1 : (out_free_s ? 1'b0 : s1_vld_q);
        s1_hit_d   = accept_s ? hit_vec_s : s1_hit_q;

        rsp_vld_d  = out_free_s ? s1_vld_q : rsp_vld_q;
        rsp_hit_d  = adv_s ? enc_s[IDX_W] : rsp_hit_q;
        rsp_idx_d  = adv_s ? enc_s[IDX_W-1:0] : rsp_idx_q;
        rsp_attr_d = adv_s ? (enc_s[IDX_W] ? attr_q[enc_s[IDX_W-1:0]] : DEFAULT_ATTR)
                           : rsp_attr_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                top_q[i]  <= {AW{1'b0}};
                attr_q[i] <= {ATTR_W{1'b0}};
            end
            s1_vld_q   <= 1'b0;
            s1_hit_q   <= {NUM_ENTRY{1'b0}};
            rsp_vld_q  <= 1'b0;
            rsp_hit_q  <= 1'b0;
            rsp_idx_q  <= {IDX_W{1'b0}};
            rsp_attr_q <= DEFAULT_ATTR;
        end else begin
            for (int i = 0; i < NUM_ENTRY; i++) begin
                top_q[i]  <= top_d[i];
                attr_q[i] <= attr_d[i];
            end
            s1_vld_q   <= s1_vld_d;
            s1_hit_q   <= s1_hit_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_attr_q <= rsp_attr_d;
        end
    end

    assign bus.lkp_rdy  = lkp_rdy_s;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_hit  = rsp_hit_q;
    assign bus.rsp_idx  = rsp_idx_q;
    assign bus.rsp_attr = rsp_attr_q;

endmodule

// File: tb/tb_ct_mmu_sysmap_match_pipe.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all cross-checked every cycle against a queue-based region-table model.
module tb_ct_mmu_sysmap_match_pipe;

    localparam int NE = 8;
    localparam logic [4:0] DEF_ATTR = 5'h0;

    typedef struct {
        int         t;
        logic       hit;
        logic [2:0] idx;
        logic [4:0] attr;
    } exp_t;

    logic clk;
    logic cpurst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   model_on = 1'b0;

    logic [27:0] m_top  [NE];
    logic [4:0]  m_attr [NE];
    logic [4:0]  rand_attr [NE];
    exp_t        exp_q [$];
    logic [8:0]  got_q [$];

    ct_mmu_sysmap_match_pipe_if #(.IDX_W(3), .AW(28), .ATTR_W(5)) bus_if ();

    ct_mmu_sysmap_match_pipe #(
        .NUM_ENTRY(NE), .IDX_W(3), .AW(28), .ATTR_W(5), .DEFAULT_ATTR(DEF_ATTR)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .bus            (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Region table semantics: the first region whose [bottom, top) range holds the address.
    function automatic exp_t model_lookup(input logic [27:0] a, input int t);
        exp_t        e;
        logic [27:0] lo;
        e.t = t; e.hit = 1'b0; e.idx = 3'd0; e.attr = DEF_ATTR;
        for (int i = 0; i < NE; i++) begin
            if (i > 0) lo = m_top[i-1];
            else       lo = 28'd0;
            if (!e.hit && a >= lo && a < m_top[i]) begin
                e.hit = 1'b1; e.idx = 3'(i); e.attr = m_attr[i];
            end
        end
        return e;
    endfunction

    // Per-cycle compare and model update. A pipeline of depth two: the oldest lookup
    // shows up two cycles after acceptance, and a third can only enter while draining.
    always @(negedge clk) begin
        logic exp_rdy, exp_vld;
        exp_t e;
        if (model_on) begin
            exp_rdy = (exp_q.size() < 2) || bus_if.rsp_rdy;
            exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].t + 2);
            chk("lkp_rdy", 32'(bus_if.lkp_rdy), 32'(exp_rdy));
            chk("rsp_vld", 32'(bus_if.rsp_vld), 32'(exp_vld));
            if (bus_if.rsp_vld && exp_vld) begin
                chk("rsp_hit",  32'(bus_if.rsp_hit),  32'(exp_q[0].hit));
                chk("rsp_idx",  32'(bus_if.rsp_idx),  32'(exp_q[0].idx));
                chk("rsp_attr", 32'(bus_if.rsp_attr), 32'(exp_q[0].attr));
            end
            if (cpurst) begin
                exp_q.delete();
            end else begin
                if (exp_vld && bus_if.rsp_rdy) void'(exp_q.pop_front());
                if (bus_if.lkp_vld && exp_rdy) begin
                    e = model_lookup(bus_if.lkp_addr, cyc);
                    exp_q.push_back(e);
                end
                if (bus_if.cfg_wen) begin
                    m_top[bus_if.cfg_idx]  = bus_if.cfg_top;
                    m_attr[bus_if.cfg_idx] = bus_if.cfg_attr;
                end
            end
        end
        if (bus_if.rsp_vld && bus_if.rsp_rdy && !cpurst)
            got_q.push_back({bus_if.rsp_hit, bus_if.rsp_idx, bus_if.rsp_attr});
        if (cpurst) begin
            model_on = 1'b1;
            exp_q.delete();
            for (int i = 0; i < NE; i++) begin
                m_top[i] = 28'd0; m_attr[i] = 5'd0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [27:0] top, input logic [4:0] attr);
        bus_if.cfg_wen = 1'b1; bus_if.cfg_idx = idx; bus_if.cfg_top = top; bus_if.cfg_attr = attr;
        tick();
        bus_if.cfg_wen = 1'b0;
    endtask

    task automatic lkp(input logic [27:0] a);
        bit done;
        done = 1'b0;
        bus_if.lkp_vld = 1'b1; bus_if.lkp_addr = a;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk); done = bus_if.lkp_rdy;
            tick();
        end
        bus_if.lkp_vld = 1'b0;
        chk("lkp_accept", 32'(done), 32'd1);
    endtask

    task automatic expect_got(input string nm, input logic h, input logic [2:0] i, input logic [4:0] a);
        logic [8:0] g;
        chk({nm, "_present"}, 32'(got_q.size() != 0), 32'd1);
        if (got_q.size() != 0) begin
            g = got_q.pop_front();
            chk({nm, "_hit"},  32'(g[8]),   32'(h));
            chk({nm, "_idx"},  32'(g[7:5]), 32'(i));
            chk({nm, "_attr"}, 32'(g[4:0]), 32'(a));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        cpurst = 1'b1;
        bus_if.cfg_wen = 1'b0; bus_if.cfg_idx = 3'd0; bus_if.cfg_top = 28'd0; bus_if.cfg_attr = 5'd0;
        bus_if.lkp_vld = 1'b0; bus_if.lkp_addr = 28'd0; bus_if.rsp_rdy = 1'b1;
        repeat (2) tick();
        cpurst = 1'b0;

        // 1: reset state, then a miss arriving exactly two cycles after acceptance
        @(negedge clk);
        chk("rst_rsp_vld", 32'(bus_if.rsp_vld), 32'd0);
        chk("rst_lkp_rdy", 32'(bus_if.lkp_rdy), 32'd1);
        chk("rst_rsp_attr", 32'(bus_if.rsp_attr), 32'(DEF_ATTR));
        tick();
        bus_if.lkp_vld = 1'b1; bus_if.lkp_addr = 28'h100;
        tick();
        bus_if.lkp_vld = 1'b0;
        @(negedge clk);
        chk("t1_vld_at_T1", 32'(bus_if.rsp_vld), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_vld_at_T2", 32'(bus_if.rsp_vld), 32'd1);
        chk("t1_hit", 32'(bus_if.rsp_hit), 32'd0);
        chk("t1_idx", 32'(bus_if.rsp_idx), 32'd0);
        chk("t1_attr", 32'(bus_if.rsp_attr), 32'(DEF_ATTR));
        tick();
        got_q.delete();

        // 2: basic region decode including both edges of a boundary
        cfg(3'd0, 28'h1000, 5'd3);
        cfg(3'd1, 28'h2000, 5'd5);
        cfg(3'd2, 28'h8000, 5'd7);
        lkp(28'hFFF); lkp(28'h1000); lkp(28'h7FFF); lkp(28'h8000);
        repeat (4) tick();
        expect_got("t2_a", 1'b1, 3'd0, 5'd3);
        expect_got("t2_b", 1'b1, 3'd1, 5'd5);
        expect_got("t2_c", 1'b1, 3'd2, 5'd7);
        expect_got("t2_d", 1'b0, 3'd0, DEF_ATTR);

        // 3: backpressure holds the first result and fills s1
        bus_if.rsp_rdy = 1'b0;
        lkp(28'h10); lkp(28'h1800);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_lkp_rdy_low", 32'(bus_if.lkp_rdy), 32'd0);
            chk("t3_hold_vld", 32'(bus_if.rsp_vld), 32'd1);
            chk("t3_hold_idx", 32'(bus_if.rsp_idx), 32'd0);
            chk("t3_hold_attr", 32'(bus_if.rsp_attr), 32'd3);
            tick();
        end
        bus_if.rsp_rdy = 1'b1;
        repeat (4) tick();
        expect_got("t3_first", 1'b1, 3'd0, 5'd3);
        expect_got("t3_second", 1'b1, 3'd1, 5'd5);
        chk("t3_no_dup", 32'(got_q.size()), 32'd0);

        // 4: config write and lookup in the same cycle see old regions
        cfg(3'd2, 28'h0, 5'd7);
        bus_if.cfg_wen = 1'b1; bus_if.cfg_idx = 3'd0; bus_if.cfg_top = 28'h4000; bus_if.cfg_attr = 5'd3;
        bus_if.lkp_vld = 1'b1; bus_if.lkp_addr = 28'h3000;
        tick();
        bus_if.cfg_wen = 1'b0;
        tick();
        bus_if.lkp_vld = 1'b0;
        repeat (4) tick();
        expect_got("t4_old", 1'b0, 3'd0, DEF_ATTR);
        expect_got("t4_new", 1'b1, 3'd0, 5'd3);

        // 5: non-monotonic tops leave entry 1 empty
        cfg(3'd0, 28'h1000, 5'd3);
        cfg(3'd1, 28'h0800, 5'd5);
        lkp(28'h0900); lkp(28'h1000); lkp(28'h0);
        repeat (4) tick();
        expect_got("t5_overlap", 1'b1, 3'd0, 5'd3);
        expect_got("t5_empty1", 1'b0, 3'd0, DEF_ATTR);
        expect_got("t5_zero", 1'b1, 3'd0, 5'd3);

        // 6: reset with two lookups in flight drops both
        bus_if.rsp_rdy = 1'b0;
        lkp(28'h10); lkp(28'h20);
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        @(negedge clk);
        chk("t6_rsp_vld", 32'(bus_if.rsp_vld), 32'd0);
        chk("t6_lkp_rdy", 32'(bus_if.lkp_rdy), 32'd1);
        tick();
        bus_if.rsp_rdy = 1'b1;
        repeat (4) tick();
        chk("t6_dropped", 32'(got_q.size()), 32'd0);
        lkp(28'h10);
        repeat (4) tick();
        expect_got("t6_cleared", 1'b0, 3'd0, DEF_ATTR);

        // Random phase; each region keeps a fixed attribute so response timing cannot blur it
        for (int i = 0; i < NE; i++) begin
            rand_attr[i] = 5'(i * 3 + 1);
            cfg(3'(i), 28'((i + 1) * 28'h1000), rand_attr[i]);
        end
        for (int n = 0; n < 800; n++) begin
            bus_if.lkp_vld = ($urandom % 3) != 0;
            sel = $urandom % 4;
            case (sel)
                0:       bus_if.lkp_addr = 28'($urandom);
                1:       bus_if.lkp_addr = m_top[$urandom % NE];
                2:       bus_if.lkp_addr = m_top[$urandom % NE] - 28'd1;
                default: bus_if.lkp_addr = 28'($urandom_range(0, 32'hA000));
            endcase
            bus_if.rsp_rdy = ($urandom % 4) != 0;
            bus_if.cfg_wen = ($urandom % 10) == 0;
            bus_if.cfg_idx = 3'($urandom % NE);
            bus_if.cfg_top = 28'($urandom_range(0, 32'hA000));
            bus_if.cfg_attr = rand_attr[bus_if.cfg_idx];
            tick();
        end
        bus_if.lkp_vld = 1'b0; bus_if.cfg_wen = 1'b0; bus_if.rsp_rdy = 1'b1;
        repeat (10) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
